// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the result LCD display block:
//   - FSM state and transfer phase enums
//   - HD44780 command bytes and the ASCII characters used when rendering
//   - number of result slots and BCD output width
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        CONVERT,
        WRITE
    } state_e;

    // Sub-phases of a single bus transfer
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } phase_e;

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY      = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] LINE1      = 8'h80;
    localparam logic [7:0] LINE2      = 8'hC0;

    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_1     = 8'h31;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_S     = 8'h53;
    localparam logic [7:0] CHAR_C     = 8'h43;

    localparam int NUM_RESULTS = 12;
    localparam int INIT_LEN    = 4;
    localparam int WRITE_LEN   = 12;
    localparam int BCD_W       = 20;   // 5 decimal digits

endpackage

// File: rtl/bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd
// Sequential double-dabble converter: DATA_W-bit unsigned binary in, five
// packed BCD digits out. One shift per cycle, DATA_W shift cycles per run.
// Ports:
//   clk     - clock
//   reset   - synchronous active-low reset
//   start_i - load bin_i and begin a conversion (one-cycle pulse)
//   bin_i   - unsigned value to convert
//   done_o  - high once conversion is complete, until the next start_i
//   bcd_o   - result digits, most significant digit in bcd_o[19:16]
// -----------------------------------------------------------------------------
module bin2bcd
    import lcd_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bin_i,
    output logic              done_o,
    output logic [BCD_W-1:0]  bcd_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CW-1:0]     cnt_q;
    logic              run_q;
    logic              done_q;
    logic [BCD_W-1:0]  adj;

    // Add 3 to every digit that is 5 or more, so the following shift carries
    // it correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign adj = dabble(bcd_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            sh_q   <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= CW'(DATA_W);
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            {bcd_q, sh_q} <= {adj[BCD_W-2:0], sh_q, 1'b0};
            cnt_q         <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_lcd_display.sv
// -----------------------------------------------------------------------------
// result_lcd_display
// Captures the 12 convolution results written by the controller and renders a
// requested one on a 16x2 HD44780 LCD (8-bit, write-only bus).
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-low reset
//   crw      - 10 = write result, 11 = display request, else idle
//   cond     - result index 0..11 (larger values ignored)
//   c_data   - signed result word, captured when crw = 10
//   lcd_rs   - 0 command, 1 character
//   lcd_rw   - always 0
//   lcd_e    - enable strobe
//   lcd_data - LCD data bus
//   busy     - high in every state except IDLE
// -----------------------------------------------------------------------------
module result_lcd_display
    import lcd_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int T_PWRUP = 1500000,
    parameter int T_EN    = 25,
    parameter int T_CMD   = 4000,
    parameter int T_CLR   = 160000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               crw,
    input  logic [4:0]               cond,
    input  logic signed [DATA_W-1:0] c_data,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic                     lcd_e,
    output logic [7:0]               lcd_data,
    output logic                     busy
);

    logic signed [DATA_W-1:0] store_q [NUM_RESULTS];

    state_e      state_q;
    phase_e      phase_q;
    logic [31:0] tmr_q;
    logic [3:0]  xfer_q;
    logic        lcd_e_q, lcd_rs_q;
    logic [7:0]  lcd_data_q;
    logic        pending_q, disp_valid_q, snap_neg_q;
    logic [3:0]  req_idx_q, last_idx_q, cur_idx_q;

    logic                     cond_ok, accept, new_req, eff_valid, bcd_done;
    logic [3:0]               cond_idx, eff_last, xfer_last;
    logic signed [DATA_W-1:0] sel;
    logic [DATA_W-1:0]        mag;
    logic [BCD_W-1:0]         bcd;
    logic [31:0]              wait_lim;
    logic [8:0]               next_byte;

    function automatic logic [8:0] init_byte(input logic [3:0] pos);
        case (pos)
            4'd0:    return {1'b0, FUNC_SET};
            4'd1:    return {1'b0, DISP_ON};
            4'd2:    return {1'b0, ENTRY};
            default: return {1'b0, CLEAR};
        endcase
    endfunction

    // {rs, byte} for position pos of the 12-transfer result frame
    function automatic logic [8:0] write_byte(input logic [3:0]       pos,
                                              input logic [3:0]       idx,
                                              input logic             neg,
                                              input logic [BCD_W-1:0] d);
        logic       rs;
        logic [7:0] ch;
        rs = 1'b1;
        ch = CHAR_0;
        case (pos)
            4'd0: begin rs = 1'b0; ch = LINE1; end
            4'd1: begin
                case (idx[3:2])
                    2'd0:    ch = CHAR_S;
                    2'd1:    ch = CHAR_0 + 8'd3;
                    default: ch = CHAR_0 + 8'd2;
                endcase
            end
            4'd2:  ch = CHAR_C;
            4'd3:  ch = CHAR_1 + {7'd0, idx[1]};
            4'd4:  ch = CHAR_1 + {7'd0, idx[0]};
            4'd5:  begin rs = 1'b0; ch = LINE2; end
            4'd6:  ch = neg ? CHAR_MINUS : CHAR_PLUS;
            4'd7:  ch = CHAR_0 + {4'd0, d[19:16]};
            4'd8:  ch = CHAR_0 + {4'd0, d[15:12]};
            4'd9:  ch = CHAR_0 + {4'd0, d[11:8]};
            4'd10: ch = CHAR_0 + {4'd0, d[7:4]};
            default: ch = CHAR_0 + {4'd0, d[3:0]};
        endcase
        return {rs, ch};
    endfunction

    assign cond_ok  = (cond < 5'(NUM_RESULTS));
    assign cond_idx = cond[3:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RESULTS; i++) store_q[i] <= '0;
        end else if (crw == 2'b10 && cond_ok) begin
            store_q[cond_idx] <= c_data;
        end
    end

    // In the accepting cycle the index being accepted already counts as the
    // last displayed one, so a request held steady does not re-queue itself.
    assign accept    = (state_q == IDLE) && pending_q;
    assign eff_valid = accept || disp_valid_q;
    assign eff_last  = accept ? req_idx_q : last_idx_q;
    assign new_req   = (crw == 2'b11) && cond_ok && (!eff_valid || cond_idx != eff_last);

    // Magnitude as unsigned: the most-negative value maps to 2^(DATA_W-1)
    assign sel = store_q[req_idx_q];
    assign mag = sel[DATA_W-1] ? $unsigned(-sel) : $unsigned(sel);

    bin2bcd #(.DATA_W(DATA_W)) u_b2b (
        .clk    (clk),
        .reset  (reset),
        .start_i(accept),
        .bin_i  (mag),
        .done_o (bcd_done),
        .bcd_o  (bcd)
    );

    assign wait_lim  = (!lcd_rs_q && lcd_data_q == CLEAR) ? 32'(T_CLR) : 32'(T_CMD);
    assign xfer_last = (state_q == INIT) ? 4'(INIT_LEN - 1) : 4'(WRITE_LEN - 1);
    assign next_byte = (state_q == INIT) ? init_byte(xfer_q + 4'd1)
                     : write_byte(xfer_q + 4'd1, cur_idx_q, snap_neg_q, bcd);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= PWR_WAIT;
            phase_q      <= PH_SETUP;
            tmr_q        <= '0;
            xfer_q       <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            pending_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            req_idx_q    <= '0;
            last_idx_q   <= '0;
            cur_idx_q    <= '0;
            snap_neg_q   <= 1'b0;
        end else begin
            if (accept) begin
                pending_q    <= 1'b0;
                last_idx_q   <= req_idx_q;
                disp_valid_q <= 1'b1;
                cur_idx_q    <= req_idx_q;
                snap_neg_q   <= sel[DATA_W-1];
            end
            if (new_req) begin
                req_idx_q <= cond_idx;
                pending_q <= 1'b1;
            end

            case (state_q)
                PWR_WAIT: begin
                    if (tmr_q == 32'(T_PWRUP - 1)) begin
                        state_q                <= INIT;
                        phase_q                <= PH_SETUP;
                        tmr_q                  <= '0;
                        xfer_q                 <= '0;
                        {lcd_rs_q, lcd_data_q} <= init_byte(4'd0);
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                INIT, WRITE: begin
                    case (phase_q)
                        PH_SETUP: begin
                            if (tmr_q == 32'd1) begin
                                phase_q <= PH_EN;
                                lcd_e_q <= 1'b1;
                                tmr_q   <= '0;
                            end else begin
                                tmr_q <= tmr_q + 32'd1;
                            end
                        end
                        PH_EN: begin
                            if (tmr_q == 32'(T_EN - 1)) begin
                                phase_q <= PH_WAIT;
                                lcd_e_q <= 1'b0;
                                tmr_q   <= '0;
                            end else begin
                                tmr_q <= tmr_q + 32'd1;
                            end
                        end
                        default: begin
                            if (tmr_q == wait_lim - 32'd1) begin
                                tmr_q <= '0;
                                if (xfer_q == xfer_last) begin
                                    state_q <= IDLE;
                                end else begin
                                    xfer_q                 <= xfer_q + 4'd1;
                                    phase_q                <= PH_SETUP;
                                    {lcd_rs_q, lcd_data_q} <= next_byte;
                                end
                            end else begin
                                tmr_q <= tmr_q + 32'd1;
                            end
                        end
                    endcase
                end
                IDLE: begin
                    if (pending_q) state_q <= CONVERT;
                end
                CONVERT: begin
                    if (bcd_done) begin
                        state_q                <= WRITE;
                        phase_q                <= PH_SETUP;
                        tmr_q                  <= '0;
                        xfer_q                 <= '0;
                        {lcd_rs_q, lcd_data_q} <= write_byte(4'd0, cur_idx_q, snap_neg_q, bcd);
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign lcd_e    = lcd_e_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = lcd_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_result_lcd_display.sv
// -----------------------------------------------------------------------------
// tb_result_lcd_display
// Directed bench for result_lcd_display with short LCD timing. A monitor logs
// every strobed {rs, byte} and every strobe width; the main sequence compares
// those logs against hand-written frames.
// -----------------------------------------------------------------------------
module tb_result_lcd_display;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         crw;
    logic [4:0]         cond;
    logic signed [15:0] c_data;
    logic               lcd_rs, lcd_rw, lcd_e, busy;
    logic [7:0]         lcd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] bytes_q [$];
    int         widths_q [$];
    logic       e_prev = 1'b0;
    int         hi_cnt = 0;

    result_lcd_display #(
        .DATA_W (16),
        .T_PWRUP(50),
        .T_EN   (2),
        .T_CMD  (5),
        .T_CLR  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .crw     (crw),
        .cond    (cond),
        .c_data  (c_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lcd_e && !e_prev) bytes_q.push_back({lcd_rs, lcd_data});
        if (lcd_e) begin
            hi_cnt = hi_cnt + 1;
        end else if (e_prev) begin
            widths_q.push_back(hi_cnt);
            hi_cnt = 0;
        end
        e_prev = lcd_e;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        bytes_q.delete();
        widths_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int k = 0;
        while (bytes_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_frame(input string tag, input int n);
        wait_bytes(n, 2000);
        wait_idle(500);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_nbytes"}, bytes_q.size(), n);
    endtask

    task automatic check_widths(input string tag);
        int bad = 0;
        foreach (widths_q[i]) if (widths_q[i] != 2) bad++;
        check({tag, "_ewidth_bad"}, bad, 0);
    endtask

    task automatic expect_init(input string tag);
        logic [8:0] exp [4];
        exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
        if (bytes_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("%s_b%0d", tag, i), bytes_q[i], exp[i]);
        end
    endtask

    task automatic expect_frame(input string tag, input int base, input string l1, input string l2);
        if (bytes_q.size() >= base + 12) begin
            check({tag, "_line1"}, bytes_q[base], 9'h080);
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_l1c%0d", tag, i), bytes_q[base+1+i], {1'b1, l1[i]});
            check({tag, "_line2"}, bytes_q[base+5], 9'h0C0);
            for (int i = 0; i < 6; i++)
                check($sformatf("%s_l2c%0d", tag, i), bytes_q[base+6+i], {1'b1, l2[i]});
        end
    endtask

    task automatic write_result(input logic [4:0] idx, input logic signed [15:0] v);
        crw    = 2'b10;
        cond   = idx;
        c_data = v;
        cyc(1);
        crw    = 2'b00;
    endtask

    initial begin
        int gap;
        int k;

        reset  = 1'b0;
        crw    = 2'b00;
        cond   = 5'd0;
        c_data = '0;
        cyc(3);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_busy", busy, 1);

        // Power-up wait and init sequence
        reset = 1'b1;
        clear_logs();
        cyc(45);
        check("pwrup_quiet", bytes_q.size(), 0);
        wait_bytes(4, 300);
        k = 0;
        while (lcd_e && k < 50) begin
            @(negedge clk);
            k++;
        end
        gap = 0;
        while (busy && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("clr_gap_ge10", (gap >= 10), 1);
        check("init_busy", busy, 0);
        check("init_nbytes", bytes_q.size(), 4);
        expect_init("init");
        check_widths("init");

        // 123 at index 0
        clear_logs();
        write_result(5'd0, 16'sd123);
        crw = 2'b11; cond = 5'd0;
        wait_frame("f0", 12);
        expect_frame("f0", 0, "SC11", "+00123");
        check_widths("f0");
        crw = 2'b00;

        // Most-negative value at index 7
        clear_logs();
        write_result(5'd7, -16'sd32768);
        crw = 2'b11; cond = 5'd7;
        wait_frame("f7", 12);
        expect_frame("f7", 0, "3C22", "-32768");
        crw = 2'b00;

        // Repeated request for 5, then an out-of-range index
        clear_logs();
        write_result(5'd5, 16'sd999);
        crw = 2'b11; cond = 5'd5;
        wait_frame("f5", 12);
        expect_frame("f5", 0, "3C12", "+00999");
        clear_logs();
        cyc(100);
        check("rep5_quiet", bytes_q.size(), 0);
        cond = 5'd14;
        cyc(30);
        check("idx14_quiet", bytes_q.size(), 0);
        check("idx14_busy", busy, 0);
        crw = 2'b00;

        // Request 9 arrives while 8 is being rendered
        clear_logs();
        write_result(5'd8, 16'sd42);
        write_result(5'd9, -16'sd5);
        crw = 2'b11; cond = 5'd8;
        cyc(30);
        check("r8_active", busy, 1);
        cond = 5'd9;
        wait_frame("f89", 24);
        expect_frame("f8", 0, "2C11", "+00042");
        expect_frame("f9", 12, "2C12", "-00005");
        cyc(60);
        check("f89_no_repeat", bytes_q.size(), 24);
        crw = 2'b00;

        // Reset in the middle of a WRITE strobe
        clear_logs();
        write_result(5'd2, 16'sd77);
        crw = 2'b11; cond = 5'd2;
        k = 0;
        while (!(lcd_e && bytes_q.size() >= 8) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("mid_e_high", lcd_e, 1);
        reset = 1'b0;
        crw   = 2'b00;
        cyc(1);
        check("mid_rst_e", lcd_e, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_data", lcd_data, 8'h00);
        cyc(1);
        reset = 1'b1;
        clear_logs();
        cyc(45);
        check("reinit_pwrup_quiet", bytes_q.size(), 0);
        wait_bytes(4, 300);
        wait_idle(300);
        check("reinit_idle", busy, 0);
        expect_init("reinit");
        clear_logs();
        crw = 2'b11; cond = 5'd2;
        wait_frame("f2", 12);
        expect_frame("f2", 0, "SC21", "+00000");
        crw = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, required finish before 1000000");
        $fatal(1);
    end

endmodule
